alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 32-bit combinational ALU.
- Width is generic. The eight single-cycle ops are registered and gain status flags.
- Adds multi-cycle unsigned multiply (shift-add) and divide/remainder (restoring), each taking WIDTH iterations.
- Sits between register-file read and writeback in the processor datapath, so the pipeline control can stall on a long op.

Parameters:
- WIDTH, 32, operand/result width in bits; must be at least 4 and a power of two.
- SHW, $clog2(WIDTH), width of the shift amount taken from B[SHW-1:0].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands and mode presented.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- mode  in  4  operation select (see Behaviour).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  primary result; low half for MUL.
- result_hi  out  WIDTH  high half of the MUL product; 0 for all other modes.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].
- flag_c  out  1  carry out for ADD; NOT borrow for SUB; 0 otherwise.
- flag_v  out  1  signed overflow for ADD/SUB; 0 otherwise.
- flag_err  out  1  divide by zero, or illegal mode.

Behaviour:
- Modes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is b[SHW-1:0].
  - 8 MULU, 9 DIVU (quotient), 10 REMU.
  - 11–15 are illegal.
- States: IDLE, BUSY, DONE.
- Reset (rst_n=0 sampled at a clk edge):
  - state goes to IDLE.
  - in_ready=1, out_valid=0.
  - result, result_hi and all flags are 0.
  - Iteration counter and partial registers are cleared.
  - Reset mid-BUSY or mid-DONE aborts the operation; nothing is emitted.
- Accept: a transfer occurs when in_valid && in_ready. in_ready is 1 only in IDLE. a, b and mode are captured into internal registers; later input changes are ignored.
- Modes 0–7: IDLE→DONE; out_valid rises the cycle after accept (latency 1).
- Modes 8–10, b != 0:
  - IDLE→BUSY; the counter loads WIDTH and decrements by one bit per cycle.
  - BUSY→DONE when the counter reaches 0.
  - out_valid rises WIDTH+1 cycles after accept.
- Divide by zero (mode 9/10, b == 0):
  - Goes straight to DONE with latency 1 and flag_err=1.
  - Quotient is all ones; remainder is a.
- Illegal mode: DONE with latency 1, result=0, result_hi=0, flag_err=1; flag_z=1.
- DONE:
  - Outputs are held stable while out_ready=0.
  - On out_valid && out_ready the block moves to IDLE next cycle with out_valid=0.
  - Outputs keep their last value until the next result is loaded.
  - Throughput is at most one op per 2 cycles.
- Arithmetic:
  - ADD/SUB use a WIDTH+1-bit sum; flag_c is bit WIDTH.
  - SUB computes a + ~b + 1.
  - flag_v = (a[msb]==b'[msb]) && (r[msb]!=a[msb]), where b' = b for ADD and ~b for SUB.
  - SRA replicates a[WIDTH-1].
  - MULU gives the full 2*WIDTH product split as {result_hi, result}.
  - flag_z/flag_n for MULU consider result only.
- Flags are computed from the final result and registered together with it.

Decomposition:
- Package alu_seq_pkg:
  - 4-bit mode constants (MODE_ADD … MODE_REMU).
  - State enum {IDLE, BUSY, DONE}.
  - Function is_multicycle(mode).
- One sub-module, seq_muldiv_core, contains the iterative shift-add multiplier and restoring divider.
  - Interface: start, a, b, op, busy, done, lo, hi.
  - The top level holds the FSM, the handshake, the single-cycle ops and the flags.

Test Plan:
- WIDTH=32 ADD: a=0x7FFFFFFF, b=1 → one cycle later out_valid=1, result=0x80000000, N=1, V=1, C=0, Z=0. SUB: a=5, b=5 → result=0, Z=1, C=1.
- MULU: a=0x0000000A, b=0x00000020 → in_ready low for 33 cycles; out_valid at accept+33; result=0x140, result_hi=0. Then a=0xFFFFFFFF, b=2 → result=0xFFFFFFFE, result_hi=1.
- DIVU/REMU: a=100, b=7 → quotient 14, remainder 2 at latency 33. DIVU with a=9, b=0 → latency 1, result=0xFFFFFFFF, flag_err=1; REMU with a=9, b=0 → result=9.
- Shifts with a=0xCC, b=2 → SLL 0x330, SRL 0x33. SRA with a=0x80000000, b=4 → 0xF8000000. Mode 12 → result 0, flag_err=1.
- Backpressure: hold out_ready=0 for 5 cycles after an AND of 0xCC & 0xCA → result stays 0xC8, out_valid stays 1, in_ready stays 0. Raise out_ready → IDLE next cycle.
- Reset mid-MULU: drive rst_n=0 at cycle 10 of BUSY → next edge in_ready=1, out_valid=0, outputs 0. A new ADD 1+2 then returns 3 at latency 1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: mode encodings, FSM states and op classification for alu_seq
package alu_seq_pkg;
  localparam logic [3:0] MODE_ADD  = 4'd0;
  localparam logic [3:0] MODE_SUB  = 4'd1;
  localparam logic [3:0] MODE_AND  = 4'd2;
  localparam logic [3:0] MODE_OR   = 4'd3;
  localparam logic [3:0] MODE_XOR  = 4'd4;
  localparam logic [3:0] MODE_SLL  = 4'd5;
  localparam logic [3:0] MODE_SRL  = 4'd6;
  localparam logic [3:0] MODE_SRA  = 4'd7;
  localparam logic [3:0] MODE_MULU = 4'd8;
  localparam logic [3:0] MODE_DIVU = 4'd9;
  localparam logic [3:0] MODE_REMU = 4'd10;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic is_multicycle(input logic [3:0] m);
    return m == MODE_MULU || m == MODE_DIVU || m == MODE_REMU;
  endfunction
endpackage

// File: rtl/seq_muldiv_core.sv
// seq_muldiv_core: iterative shift-add multiplier and restoring divider, one bit per cycle
module seq_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] m, acc_hi, acc_lo;
  logic             op_r;
  logic [WIDTH:0]   add, rem_sh, diff;
  assign busy = cnt != '0;
  assign done = cnt == CW'(1);
  // lo/hi are the values after this cycle's step, so they hold the answer while done is high
  always_comb begin
    add = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    diff = rem_sh - {1'b0, m};
    lo = op_r ? {acc_lo[WIDTH-2:0], ~diff[WIDTH]} : {add[0], acc_lo[WIDTH-1:1]};
    hi = op_r ? (diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]) : add[WIDTH:1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      m <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      op_r <= 1'b0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
      m <= b;
      acc_hi <= '0;
      acc_lo <= a;
      op_r <= op;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      acc_hi <= hi;
      acc_lo <= lo;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered flags and multi-cycle multiply/divide
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err
);
  state_t           state, nstate;
  logic [3:0]       mode_r;
  logic             sub, go_busy, accept, ld, core_busy, core_done;
  logic [WIDTH-1:0] bx, r1, nr, nh, core_lo, core_hi;
  logic [WIDTH:0]   sum;
  logic             c1, v1, e1;
  logic [SHW-1:0]   sh;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_ready && in_valid;
  // divide by zero short-circuits to a latency-1 error result
  assign go_busy = is_multicycle(mode) && !(mode != MODE_MULU && b == '0);
  assign ld = (accept && !go_busy) || core_done;
  assign sub = mode == MODE_SUB;
  assign bx = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  assign sh = b[SHW-1:0];
  always_comb begin
    r1 = '0;
    c1 = 1'b0;
    v1 = 1'b0;
    e1 = 1'b0;
    case (mode)
      MODE_ADD, MODE_SUB: begin
        r1 = sum[WIDTH-1:0];
        c1 = sum[WIDTH];
        v1 = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      MODE_AND: r1 = a & b;
      MODE_OR:  r1 = a | b;
      MODE_XOR: r1 = a ^ b;
      MODE_SLL: r1 = a << sh;
      MODE_SRL: r1 = a >> sh;
      MODE_SRA: r1 = $signed(a) >>> sh;
      MODE_MULU: r1 = '0;
      MODE_DIVU: begin
        r1 = '1;
        e1 = 1'b1;
      end
      MODE_REMU: begin
        r1 = a;
        e1 = 1'b1;
      end
      default: e1 = 1'b1;
    endcase
  end
  assign nr = core_busy ? (mode_r == MODE_REMU ? core_hi : core_lo) : r1;
  assign nh = core_busy && mode_r == MODE_MULU ? core_hi : '0;
  assign nstate = state == IDLE ? (in_valid ? (go_busy ? BUSY : DONE) : IDLE) :
                  state == BUSY ? (core_done ? DONE : BUSY) :
                  (out_ready ? IDLE : DONE);
  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept && go_busy),
    .a(a),
    .b(b),
    .op(mode != MODE_MULU),
    .busy(core_busy),
    .done(core_done),
    .lo(core_lo),
    .hi(core_hi)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      mode_r <= '0;
      result <= '0;
      result_hi <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      flag_err <= 1'b0;
    end else begin
      state <= nstate;
      if (accept) mode_r <= mode;
      if (ld) begin
        result <= nr;
        result_hi <= nh;
        flag_z <= nr == '0;
        flag_n <= nr[WIDTH-1];
        flag_c <= !core_busy && c1;
        flag_v <= !core_busy && v1;
        flag_err <= !core_busy && e1;
      end
    end
  end
endmodule
